// File: rtl/axis_i2s_slave_if.sv
// AXI-Stream bundle for the I2S slave transceiver.
// Holds the transmit (sink) channel and the receive (source) channel.
//   tx_axis_s_* : packets to serialize (data[23:0] used, last=1 marks the right word)
//   rx_axis_m_* : deserialized packets ({8'b0, sample}, last=1 on the right word)
// The slave modport is the transceiver's view of the bundle. The master modport is
// the view of whatever produces tx packets and consumes rx packets.
interface axis_i2s_slave_if;
    logic [31:0] tx_axis_s_data;
    logic        tx_axis_s_valid;
    logic        tx_axis_s_ready;
    logic        tx_axis_s_last;
    logic [31:0] rx_axis_m_data;
    logic        rx_axis_m_valid;
    logic        rx_axis_m_ready;
    logic        rx_axis_m_last;

    modport slave (
        input  tx_axis_s_data,
        input  tx_axis_s_valid,
        input  tx_axis_s_last,
        output tx_axis_s_ready,
        output rx_axis_m_data,
        output rx_axis_m_valid,
        output rx_axis_m_last,
        input  rx_axis_m_ready
    );

    modport master (
        output tx_axis_s_data,
        output tx_axis_s_valid,
        output tx_axis_s_last,
        input  tx_axis_s_ready,
        input  rx_axis_m_data,
        input  rx_axis_m_valid,
        input  rx_axis_m_last,
        output rx_axis_m_ready
    );
endinterface

// File: rtl/axis_i2s_slave.sv
// I2S slave transceiver with AXI-Stream packet interfaces.
// The external SCLK/LRCK/SDIN are oversampled in the axis_clk domain. Each left+right
// frame received is turned into a two-beat AXIS packet, and each two-beat AXIS packet
// staged on the tx side is serialized onto i2s_sdout in the following frame.
// Format: 24-bit samples, MSB first, one SCLK of delay after each LRCK edge.
// Ports:
//   axis_clk, axis_reset : system clock and asynchronous active-high reset
//   i2s_sclk, i2s_lrck   : serial clock and word select from the external master
//   i2s_sdin, i2s_sdout  : serial data in from the master, serial data out to it
//   axis                 : AXIS tx sink and rx source (see axis_i2s_slave_if)
//   tx_underrun          : one-cycle pulse when a frame starts with no staged tx packet
//   rx_overrun           : one-cycle pulse when a completed rx frame has to be dropped
module axis_i2s_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            axis_clk,
    input  logic            axis_reset,
    input  logic            i2s_sclk,
    input  logic            i2s_lrck,
    input  logic            i2s_sdin,
    output logic            i2s_sdout,
    axis_i2s_slave_if.slave axis,
    output logic            tx_underrun,
    output logic            rx_overrun
);

    logic [SYNC_STAGES-1:0] sclkSync_q, lrckSync_q, sdinSync_q;
    logic                   sclkHist_q;

    logic        lrckPrev_q, lrckPrev_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic        ch_q, ch_d;
    logic        locked_q, locked_d;

    logic [23:0] rxShift_q, rxShift_d;
    logic [23:0] rxLeft_q, rxLeft_d;
    logic        leftOk_q, leftOk_d;
    logic [23:0] outLeft_q, outLeft_d;
    logic [23:0] outRight_q, outRight_d;
    logic        rxValid_q, rxValid_d;
    logic        rxLast_q, rxLast_d;
    logic        rxOverrun_q, rxOverrun_d;

    logic [23:0] bufLeft_q, bufLeft_d;
    logic [23:0] bufRight_q, bufRight_d;
    logic        full_q, full_d;
    logic        txReady_q, txReady_d;
    logic [23:0] actLeft_q, actLeft_d;
    logic [23:0] actRight_q, actRight_d;
    logic        txUnderrun_q, txUnderrun_d;
    logic [23:0] txShift_q, txShift_d;
    logic        sdout_q, sdout_d;

    logic        sclkS, lrckS, sdinS;
    logic        sclkRise, sclkFall;
    logic        lrckChange, leftStart, txHs;
    logic [4:0]  cntNext;
    logic        unusedTxBits;

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign lrckS    = lrckSync_q[SYNC_STAGES-1];
    assign sdinS    = sdinSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkHist_q;
    assign sclkFall = ~sclkS & sclkHist_q;

    // Only the low 24 bits of a tx beat carry audio.
    assign unusedTxBits = &{1'b0, axis.tx_axis_s_data[31:24]};

    assign i2s_sdout             = sdout_q;
    assign tx_underrun           = txUnderrun_q;
    assign rx_overrun            = rxOverrun_q;
    assign axis.tx_axis_s_ready  = txReady_q;
    assign axis.rx_axis_m_valid  = rxValid_q;
    assign axis.rx_axis_m_last   = rxLast_q;
    assign axis.rx_axis_m_data   = {8'h00, rxLast_q ? outRight_q : outLeft_q};

    // Synchronizers for the asynchronous I2S inputs. sdin and lrck go through the same
    // depth as sclk so they stay aligned with the sclk strobes.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            sclkSync_q <= '0;
            lrckSync_q <= '0;
            sdinSync_q <= '0;
            sclkHist_q <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], i2s_sclk};
            lrckSync_q <= {lrckSync_q[SYNC_STAGES-2:0], i2s_lrck};
            sdinSync_q <= {sdinSync_q[SYNC_STAGES-2:0], i2s_sdin};
            sclkHist_q <= sclkS;
        end
    end

    // Next-state logic for slot tracking, rx deserializer, tx staging and tx serializer.
    always_comb begin
        lrckPrev_d   = lrckPrev_q;
        bitCnt_d     = bitCnt_q;
        ch_d         = ch_q;
        locked_d     = locked_q;
        rxShift_d    = rxShift_q;
        rxLeft_d     = rxLeft_q;
        leftOk_d     = leftOk_q;
        outLeft_d    = outLeft_q;
        outRight_d   = outRight_q;
        rxValid_d    = rxValid_q;
        rxLast_d     = rxLast_q;
        rxOverrun_d  = 1'b0;
        bufLeft_d    = bufLeft_q;
        bufRight_d   = bufRight_q;
        full_d       = full_q;
        actLeft_d    = actLeft_q;
        actRight_d   = actRight_q;
        txUnderrun_d = 1'b0;
        txShift_d    = txShift_q;
        sdout_d      = sdout_q;

        lrckChange = sclkRise && (lrckS != lrckPrev_q);
        leftStart  = lrckChange && !lrckS;
        txHs       = axis.tx_axis_s_valid && txReady_q;

        // The delay slot after an LRCK edge is slot 0; the counter saturates so a
        // master running more than 32 slots per channel cannot wrap into data slots.
        if (lrckChange) begin
            cntNext = 5'd0;
        end else if (bitCnt_q == 5'd31) begin
            cntNext = 5'd31;
        end else begin
            cntNext = bitCnt_q + 5'd1;
        end

        if (sclkRise) begin
            lrckPrev_d = lrckS;
            bitCnt_d   = cntNext;
            if (lrckChange) begin
                ch_d = lrckS;
            end
        end

        if (leftStart) begin
            locked_d = 1'b1;
            leftOk_d = 1'b0;
        end

        // A right word only becomes a packet when its left word of the same frame was
        // seen, so locking mid-frame never produces a half-filled packet.
        if (sclkRise && locked_q && (cntNext >= 5'd1) && (cntNext <= 5'd24)) begin
            rxShift_d = {rxShift_q[22:0], sdinS};
            if (cntNext == 5'd24) begin
                if (!ch_q) begin
                    rxLeft_d = rxShift_d;
                    leftOk_d = 1'b1;
                end else if (leftOk_q) begin
                    if (!rxValid_q) begin
                        outLeft_d  = rxLeft_q;
                        outRight_d = rxShift_d;
                        rxValid_d  = 1'b1;
                        rxLast_d   = 1'b0;
                    end else begin
                        rxOverrun_d = 1'b1;
                    end
                end
            end
        end

        if (rxValid_q && axis.rx_axis_m_ready) begin
            if (!rxLast_q) begin
                rxLast_d = 1'b1;
            end else begin
                rxValid_d = 1'b0;
                rxLast_d  = 1'b0;
            end
        end

        // Frame start consumes the buffer state from before this cycle; a right beat
        // accepted on the same cycle stays staged for the following frame.
        if (leftStart) begin
            if (full_q) begin
                actLeft_d  = bufLeft_q;
                actRight_d = bufRight_q;
                full_d     = 1'b0;
            end else begin
                actLeft_d    = 24'd0;
                actRight_d   = 24'd0;
                txUnderrun_d = locked_q;
            end
        end

        if (txHs) begin
            if (axis.tx_axis_s_last) begin
                bufRight_d = axis.tx_axis_s_data[23:0];
                full_d     = 1'b1;
            end else begin
                bufLeft_d = axis.tx_axis_s_data[23:0];
            end
        end

        txReady_d = ~full_d;

        if (lrckChange) begin
            txShift_d = lrckS ? actRight_d : actLeft_d;
        end

        // Driving on the falling strobe puts each bit on the line half an SCLK before
        // the master samples it on the rising edge.
        if (sclkFall) begin
            if (locked_q && (bitCnt_q <= 5'd23)) begin
                sdout_d   = txShift_q[23];
                txShift_d = {txShift_q[22:0], 1'b0};
            end else begin
                sdout_d = 1'b0;
            end
        end

        if (!locked_q) begin
            sdout_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            lrckPrev_q   <= 1'b0;
            bitCnt_q     <= 5'd0;
            ch_q         <= 1'b0;
            locked_q     <= 1'b0;
            rxShift_q    <= 24'd0;
            rxLeft_q     <= 24'd0;
            leftOk_q     <= 1'b0;
            outLeft_q    <= 24'd0;
            outRight_q   <= 24'd0;
            rxValid_q    <= 1'b0;
            rxLast_q     <= 1'b0;
            rxOverrun_q  <= 1'b0;
            bufLeft_q    <= 24'd0;
            bufRight_q   <= 24'd0;
            full_q       <= 1'b0;
            txReady_q    <= 1'b0;
            actLeft_q    <= 24'd0;
            actRight_q   <= 24'd0;
            txUnderrun_q <= 1'b0;
            txShift_q    <= 24'd0;
            sdout_q      <= 1'b0;
        end else begin
            lrckPrev_q   <= lrckPrev_d;
            bitCnt_q     <= bitCnt_d;
            ch_q         <= ch_d;
            locked_q     <= locked_d;
            rxShift_q    <= rxShift_d;
            rxLeft_q     <= rxLeft_d;
            leftOk_q     <= leftOk_d;
            outLeft_q    <= outLeft_d;
            outRight_q   <= outRight_d;
            rxValid_q    <= rxValid_d;
            rxLast_q     <= rxLast_d;
            rxOverrun_q  <= rxOverrun_d;
            bufLeft_q    <= bufLeft_d;
            bufRight_q   <= bufRight_d;
            full_q       <= full_d;
            txReady_q    <= txReady_d;
            actLeft_q    <= actLeft_d;
            actRight_q   <= actRight_d;
            txUnderrun_q <= txUnderrun_d;
            txShift_q    <= txShift_d;
            sdout_q      <= sdout_d;
        end
    end

endmodule

// File: doc/axis_i2s_slave.md
# axis_i2s_slave

I2S slave transceiver with AXI-Stream packet interfaces. It is the counterpart of our I2S master controller. The block receives externally generated SCLK/LRCK, oversamples them in the axis_clk domain, and deserializes the serial input into 2-word AXIS packets (left, right). It also serializes 2-word AXIS packets onto its serial output. It is the codec-side model/endpoint used on the far end of the Pmod I2S2-style link, either as a loopback partner for the master or when the FPGA must slave to an external master.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each of i2s_sclk, i2s_lrck, i2s_sdin (≥2)
- axis_clk  in  1  system clock; all logic on rising edge
- axis_reset  in  1  asynchronous, active-high reset
- i2s_sclk  in  1  external serial clock (asynchronous to axis_clk)
- i2s_lrck  in  1  external word select; 0 = left, 1 = right
- i2s_sdin  in  1  serial data from master
- i2s_sdout  out  1  serial data to master
- tx_axis_s_data  in  32  sample to transmit; bits [23:0] used
- tx_axis_s_valid  in  1  AXIS slave valid
- tx_axis_s_ready  out  1  AXIS slave ready
- tx_axis_s_last  in  1  1 = right word (ends packet), 0 = left word
- rx_axis_m_data  out  32  {8'b0, sample[23:0]}
- rx_axis_m_valid  out  1  AXIS master valid
- rx_axis_m_ready  in  1  AXIS master ready
- rx_axis_m_last  out  1  1 on right word
- tx_underrun  out  1  one-cycle pulse: frame started with no staged tx packet
- rx_overrun  out  1  one-cycle pulse: completed rx frame dropped

## Operation
- Format: 24-bit, MSB first, data delayed one SCLK after each LRCK transition (standard I2S). Bits past slot 24 are ignored on input and driven 0 on output.
- Sync: the three inputs pass through SYNC_STAGES flops. Rising/falling strobes come from comparing the last sync stage with one extra history flop.
- Slot counter bit_cnt (5 bit, saturates at 31), on each sclk rising strobe:
  - If the synced lrck differs from the lrck captured at the previous rising strobe: bit_cnt←0 (delay slot), ch←lrck.
  - Otherwise bit_cnt←bit_cnt+1.
  - Data slots are bit_cnt 1..24.
- Frame lock: cleared by reset. Set at the first rising strobe detecting a 1→0 lrck change (left start). Nothing is captured, transmitted or flagged while unlocked; i2s_sdout=0.
- RX:
  - On a rising strobe with the new bit_cnt in 1..24, shift synced sdin into rx_shift.
  - At bit_cnt=24 with ch=0, latch rx_left and set left_ok.
  - At bit_cnt=24 with ch=1 and left_ok: if rx_axis_m_valid=0, load rx_left/rx_shift into the output pair, valid←1, last←0. Otherwise pulse rx_overrun and discard the frame.
  - Clear left_ok at every left start.
- RX AXIS: data = last ? right : left. A handshake with last=0 sets last←1. A handshake with last=1 sets valid←0, last←0.
- TX staging buffer (one packet):
  - ready=1 whenever the buffer is not full.
  - A beat with last=0 writes the left word; repeated non-last beats overwrite it.
  - A beat with last=1 writes the right word and marks the buffer full; ready falls the next cycle.
- TX frame start (rising strobe at left start):
  - If full: copy to the active pair, clear full.
  - Else: active pair←0 and pulse tx_underrun. Not flagged on the very first lock.
- TX shift:
  - At bit_cnt=0, load tx_shift with the active word for ch.
  - On each falling strobe with bit_cnt in 0..23: i2s_sdout←tx_shift[23], tx_shift<<1.
  - Otherwise i2s_sdout←0.
- Requirement on master: SCLK high and low phases each ≥ SYNC_STAGES+3 axis_clk cycles; LRCK changes only on SCLK falling edges.

## Timing
- Reset values: tx_axis_s_ready=0 (rises first cycle after release), rx_axis_m_valid=0, rx_axis_m_last=0, rx_axis_m_data=0, i2s_sdout=0, tx_underrun=0, rx_overrun=0. Frame lock, counters, buffers and flags cleared.
- Reset mid-frame: partial rx/tx data discarded; a staged tx packet is lost; relock required.
- Strobe latency: SYNC_STAGES+1 axis_clk edges after the first axis_clk edge that samples the new sclk level.
- rx_axis_m_valid rises on the cycle after the slot-24 right-channel strobe.
- i2s_sdout changes one cycle after the falling strobe.
- Simultaneous tx handshake (last=1) and frame start: the copy uses the old buffer state; the new packet stays staged for the next frame.
- Simultaneous rx handshake (last=1) and frame completion: the handshake wins; the new frame is dropped with rx_overrun.

## Test plan
- Master model (SCLK period 16 clk, 64 SCLK/frame) sends L=24'hA5A5A5, R=24'h3C3C3C → one packet: 32'h00A5A5A5 (last=0), then 32'h003C3C3C (last=1).
- Stage tx packet L=32'h00800001, R=32'h007FFFFE before the frame → master captures the exact bits; sdout is 0 in slots 0 and 25..31.
- No tx packet for one frame after lock → tx_underrun pulses once; both channels transmit 0.
- Hold rx_axis_m_ready=0 across two frames → first packet held unchanged; rx_overrun pulses once; second frame lost.
- Start mid-right channel → no rx packet until after the first full left+right frame.
- Assert axis_reset mid-left-channel for 3 cycles → all outputs take reset values immediately; the next full frame after relock is received correctly.
